// File: rtl/cdriver_axil.sv
// rtl/cdriver_axil.sv - AXI4-Lite single-command master engine with GPIO out/in
//
// Runs one register read or write at a time on an AXI4-Lite master port.
// A watchdog aborts any transaction that stays in flight for TIMEOUT_CYCLES.
// Also holds a GPIO output register and double-flop synchronizes GPIO inputs.
//
// Ports:
//   aclk, aclk_reset_n      clock, asynchronous active-low reset
//   cmd_*                   command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                   one-cycle completion (valid, rdata, resp, timeout)
//   m_aw*/m_w*/m_b*         AXI4-Lite write address / data / response channels
//   m_ar*/m_r*              AXI4-Lite read address / data channels
//   gpio_out_we/_wdata      load strobe and value for gpio_out
//   gpio_out                registered GPIO outputs
//   gpio_in / gpio_in_sync  asynchronous GPIO inputs and synchronized copies
module cdriver_axil #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int NUMB_INPUT_IO  = 1,
    parameter int NUMB_OUTPUT_IO = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      aclk_reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic                      gpio_out_we,
    input  logic [NUMB_OUTPUT_IO-1:0] gpio_out_wdata,
    output logic [NUMB_OUTPUT_IO-1:0] gpio_out,
    input  logic [NUMB_INPUT_IO-1:0]  gpio_in,
    output logic [NUMB_INPUT_IO-1:0]  gpio_in_sync
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WDOG_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RD_A = 3'd3,
        S_RD_D = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [STRB_WIDTH-1:0]     r_wstrb;
    logic [WDOG_WIDTH-1:0]     r_wdog;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                r_resp;
    logic                      r_timeout;
    logic [NUMB_OUTPUT_IO-1:0] r_gpio_out;
    logic [NUMB_INPUT_IO-1:0]  r_gpio_meta;
    logic [NUMB_INPUT_IO-1:0]  r_gpio_sync;

    logic w_accept;
    logic w_busy;
    logic w_timeout;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_abort;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_busy    = (r_state == S_WR) || (r_state == S_WB) ||
                       (r_state == S_RD_A) || (r_state == S_RD_D);
    assign w_timeout = w_busy && (r_wdog == WDOG_LAST);
    assign w_aw_hs   = (r_state == S_WR) && !r_aw_done && m_awready;
    assign w_w_hs    = (r_state == S_WR) && !r_w_done && m_wready;
    assign w_b_hs    = (r_state == S_WB) && m_bvalid;
    assign w_r_hs    = (r_state == S_RD_D) && m_rvalid;
    // A response landing on the watchdog's last cycle was really accepted,
    // so it wins over the abort.
    assign w_abort   = w_timeout && !(w_b_hs || w_r_hs);

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next = cmd_write ? S_WR : S_RD_A;
            end
            S_WR: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if ((r_aw_done || m_awready) && (r_w_done || m_wready)) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                if (m_bvalid || w_timeout) w_next = S_DONE;
            end
            S_RD_A: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (m_arready) begin
                    w_next = S_RD_D;
                end
            end
            S_RD_D: begin
                if (m_rvalid || w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (r_state == S_IDLE);
        m_awvalid   = (r_state == S_WR) && !r_aw_done;
        m_wvalid    = (r_state == S_WR) && !r_w_done;
        m_bready    = (r_state == S_WB);
        m_arvalid   = (r_state == S_RD_A);
        m_rready    = (r_state == S_RD_D);
        rsp_valid   = (r_state == S_DONE);
        rsp_rdata   = (r_state == S_DONE) ? r_rdata : '0;
        rsp_resp    = (r_state == S_DONE) ? r_resp : 2'b00;
        rsp_timeout = (r_state == S_DONE) && r_timeout;
        m_awaddr    = r_addr;
        m_araddr    = r_addr;
        m_awprot    = 3'b000;
        m_arprot    = 3'b000;
        m_wdata     = r_wdata;
        m_wstrb     = r_wstrb;
        gpio_out    = r_gpio_out;
        gpio_in_sync = r_gpio_sync;
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wdog    <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_wdog    <= '0;
                r_rdata   <= '0;
                r_resp    <= 2'b00;
                r_timeout <= 1'b0;
            end else begin
                if (w_busy) r_wdog <= r_wdog + 1'b1;
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
                if (w_b_hs) begin
                    r_resp <= m_bresp;
                end else if (w_r_hs) begin
                    r_rdata <= m_rdata;
                    r_resp  <= m_rresp;
                end else if (w_abort) begin
                    r_rdata   <= '0;
                    r_resp    <= 2'b10;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            r_gpio_out  <= '0;
            r_gpio_meta <= '0;
            r_gpio_sync <= '0;
        end else begin
            if (gpio_out_we) r_gpio_out <= gpio_out_wdata;
            r_gpio_meta <= gpio_in;
            r_gpio_sync <= r_gpio_meta;
        end
    end

endmodule

// File: tb/tb_cdriver_axil.sv
// tb/tb_cdriver_axil.sv - self-checking bench for cdriver_axil
module tb_cdriver_axil;

    logic        aclk = 1'b0;
    logic        aclk_reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [10:0] m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic        gpio_out_we;
    logic [1:0]  gpio_out_wdata, gpio_out;
    logic [0:0]  gpio_in, gpio_in_sync;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    cdriver_axil dut (
        .aclk(aclk), .aclk_reset_n(aclk_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .gpio_out_we(gpio_out_we), .gpio_out_wdata(gpio_out_wdata), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync)
    );

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic        hammer;
        int          e_lat, e_aw, e_w, e_ar;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        logic        e_to;
    } vec_t;

    localparam int NEVER = 65535;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_slave();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int  c, n_aw, n_w, n_ar, aw_wt, w_wt, ar_wt, b_wt, r_wt, perr, lat;
        bit  aw_hs, w_hs, ar_hs, b_hs, r_hs, done;
        logic [31:0] g_rdata;
        logic [1:0]  g_resp;
        logic        g_to;
        n_aw = 0; n_w = 0; n_ar = 0; aw_wt = 0; w_wt = 0; ar_wt = 0; b_wt = 0; r_wt = 0;
        perr = 0; lat = -1; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; done = 0;
        g_rdata = 32'hxxxx_xxxx; g_resp = 2'bxx; g_to = 1'bx;
        @(negedge aclk);
        chk({nm, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        c = 0;
        while (!done && c < 2000) begin
            @(negedge aclk);
            c++;
            if (rsp_valid) begin
                done = 1; lat = c; cmd_valid = 0;
                g_rdata = rsp_rdata; g_resp = rsp_resp; g_to = rsp_timeout;
            end else begin
                cmd_valid = v.hammer;
                if (v.hammer) begin
                    cmd_write = 1; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
                end
                if (cmd_ready) perr++;
                clear_slave();
                if (aw_hs && w_hs && !b_hs) begin
                    if (b_wt >= v.b_d) begin
                        m_bvalid = 1; m_bresp = v.sresp; b_hs = m_bready;
                    end else b_wt++;
                end
                if (ar_hs && !r_hs) begin
                    if (r_wt >= v.r_d) begin
                        m_rvalid = 1; m_rdata = v.srdata; m_rresp = v.sresp; r_hs = m_rready;
                    end else r_wt++;
                end
                if (m_awvalid) begin
                    n_aw++;
                    if (m_awaddr !== v.addr || m_awprot !== 3'b000) perr++;
                    if (aw_wt >= v.aw_d) begin m_awready = 1; aw_hs = 1; end else aw_wt++;
                end
                if (m_wvalid) begin
                    n_w++;
                    if (m_wdata !== v.wdata || m_wstrb !== v.wstrb) perr++;
                    if (w_wt >= v.w_d) begin m_wready = 1; w_hs = 1; end else w_wt++;
                end
                if (m_arvalid) begin
                    n_ar++;
                    if (m_araddr !== v.addr || m_arprot !== 3'b000) perr++;
                    if (ar_wt >= v.ar_d) begin m_arready = 1; ar_hs = 1; end else ar_wt++;
                end
            end
        end
        chk({nm, "_latency"}, lat, v.e_lat);
        chk({nm, "_rdata"}, g_rdata, v.e_rdata);
        chk({nm, "_resp"}, {30'd0, g_resp}, {30'd0, v.e_resp});
        chk({nm, "_timeout"}, {31'd0, g_to}, {31'd0, v.e_to});
        chk({nm, "_aw_cycles"}, n_aw, v.e_aw);
        chk({nm, "_w_cycles"}, n_w, v.e_w);
        chk({nm, "_ar_cycles"}, n_ar, v.e_ar);
        chk({nm, "_protocol_errs"}, perr, 0);
        @(negedge aclk);
        clear_slave();
        cmd_valid = 0;
        chk({nm, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_back_idle"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    function automatic vec_t mk(input logic wr, input logic [10:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int aw_d, input int w_d, input int b_d,
                                input int ar_d, input int r_d, input logic [1:0] sresp,
                                input logic [31:0] srdata, input logic hammer, input int e_lat,
                                input int e_aw, input int e_w, input int e_ar,
                                input logic [31:0] e_rdata, input logic [1:0] e_resp, input logic e_to);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.sresp = sresp; v.srdata = srdata; v.hammer = hammer;
        v.e_lat = e_lat; v.e_aw = e_aw; v.e_w = e_w; v.e_ar = e_ar;
        v.e_rdata = e_rdata; v.e_resp = e_resp; v.e_to = e_to;
        return v;
    endfunction

    logic exp_sync[6];

    initial begin
        //            wr  addr     wdata         strb  aw w  b      ar     r  sresp  srdata        hm  lat  naw nw nar  e_rdata       e_resp e_to
        vecs[0] = mk(1, 11'h010, 32'h0000_00AA, 4'hF, 0, 0, 0,     0,     0, 2'b00, 32'h0,        0, 3,    1, 1, 0,    32'h0,        2'b00, 0);
        vecs[1] = mk(0, 11'h010, 32'h0,         4'h0, 0, 0, 0,     0,     5, 2'b00, 32'hDEADBEEF, 0, 8,    0, 0, 1,    32'hDEADBEEF, 2'b00, 0);
        vecs[2] = mk(1, 11'h7FC, 32'h1234_5678, 4'h5, 4, 0, 1,     0,     0, 2'b00, 32'h0,        0, 8,    5, 1, 0,    32'h0,        2'b00, 0);
        vecs[3] = mk(1, 11'h004, 32'hCAFE_0001, 4'h3, 0, 3, 0,     0,     0, 2'b11, 32'h0,        0, 6,    1, 4, 0,    32'h0,        2'b11, 0);
        vecs[4] = mk(0, 11'h3A0, 32'h0,         4'h0, 0, 0, 0,     2,     0, 2'b10, 32'h0BADF00D, 0, 5,    0, 0, 3,    32'h0BADF00D, 2'b10, 0);
        vecs[5] = mk(0, 11'h020, 32'h0,         4'h0, 0, 0, 0,     NEVER, 0, 2'b00, 32'h1111_1111, 0, 1025, 0, 0, 1024, 32'h0,       2'b10, 1);
        vecs[6] = mk(1, 11'h040, 32'h5555_AAAA, 4'hF, 2, 2, NEVER, 0,     0, 2'b00, 32'h0,        0, 1025, 3, 3, 0,    32'h0,        2'b10, 1);
        vecs[7] = mk(0, 11'h155, 32'h0,         4'h0, 0, 0, 0,     3,     1, 2'b00, 32'h5A5A_0001, 1, 7,    0, 0, 4,    32'h5A5A_0001, 2'b00, 0);
        exp_sync = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        aclk_reset_n = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        clear_slave();
        gpio_out_we = 0; gpio_out_wdata = 0; gpio_in = 0;
        repeat (2) @(negedge aclk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_valids", {27'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'd0);
        chk("reset_rsp", {29'd0, rsp_valid, rsp_timeout, |rsp_resp}, 32'd0);
        chk("reset_addr", {21'd0, m_awaddr | m_araddr}, 32'd0);
        chk("reset_gpio", {29'd0, gpio_out, gpio_in_sync}, 32'd0);
        aclk_reset_n = 1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // late B/R arriving while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            m_bvalid = 1; m_bresp = 2'b01; m_rvalid = 1; m_rdata = 32'h7777_7777;
            #1;
            chk("late_readies", {30'd0, m_bready, m_rready}, 32'd0);
            @(negedge aclk);
            chk("late_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end
        clear_slave();

        // GPIO output register
        @(negedge aclk);
        gpio_out_we = 1; gpio_out_wdata = 2'b10;
        chk("gpio_out_before", {30'd0, gpio_out}, 32'd0);
        @(negedge aclk);
        chk("gpio_out_loaded", {30'd0, gpio_out}, 32'd2);
        gpio_out_we = 0; gpio_out_wdata = 2'b01;
        @(negedge aclk);
        chk("gpio_out_hold", {30'd0, gpio_out}, 32'd2);

        // GPIO input synchronizer: 3-cycle pulse
        gpio_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge aclk);
            if (k == 3) gpio_in = 1'b0;
            chk($sformatf("gpio_sync_k%0d", k), {31'd0, gpio_in_sync[0]}, {31'd0, exp_sync[k-1]});
        end

        // reset asserted while waiting in WB
        gpio_out_we = 1; gpio_out_wdata = 2'b11;
        @(negedge aclk);
        gpio_out_we = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 11'h0AA; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 0; m_awready = 1; m_wready = 1;
        @(negedge aclk);
        clear_slave();
        chk("wb_bready", {30'd0, m_bready, cmd_ready}, 32'd2);
        #2 aclk_reset_n = 0;
        #1;
        chk("rst_async_bready", {31'd0, m_bready}, 32'd0);
        chk("rst_async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_async_gpio", {30'd0, gpio_out}, 32'd0);
        chk("rst_async_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge aclk);
        aclk_reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("post_rst_quiet", {29'd0, rsp_valid, m_bready, cmd_ready}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdriver_axil.md
Name: cdriver_axil

Overview:
- Synthesizable AXI4-Lite master engine with a small GPIO block. It is the host-side register-access driver in front of the system's AXI-Lite slave fabric.
- Accepts one read or write command at a time on a simple valid/ready command port and runs it as an AXI4-Lite transaction.
- Returns read data and response code, with a watchdog timeout.
- Also provides a GPIO output register (for example, model-select lines) and synchronized GPIO inputs (for example, a DMA interrupt).

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width (multiple of 8).
- ADDR_WIDTH, 11, AXI-Lite address width.
- NUMB_INPUT_IO, 1, number of GPIO inputs.
- NUMB_OUTPUT_IO, 2, number of GPIO outputs.
- TIMEOUT_CYCLES, 1024, cycles a transaction may wait before abort.

Ports:
- aclk  in  1  clock.
- aclk_reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, command accepted when valid&ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted.
- m_awaddr out ADDR_WIDTH; m_awprot out 3; m_awvalid out 1; m_awready in 1.
- m_wdata out DATA_WIDTH; m_wstrb out DATA_WIDTH/8; m_wvalid out 1; m_wready in 1.
- m_bresp in 2; m_bvalid in 1; m_bready out 1.
- m_araddr out ADDR_WIDTH; m_arprot out 3; m_arvalid out 1; m_arready in 1.
- m_rdata in DATA_WIDTH; m_rresp in 2; m_rvalid in 1; m_rready out 1.
- gpio_out_we  in  1  load gpio_out from gpio_out_wdata.
- gpio_out_wdata  in  NUMB_OUTPUT_IO  new output value.
- gpio_out  out  NUMB_OUTPUT_IO  registered GPIO outputs.
- gpio_in  in  NUMB_INPUT_IO  asynchronous GPIO inputs.
- gpio_in_sync  out  NUMB_INPUT_IO  2-flop synchronized inputs.

Behaviour:
- Reset (async assert, sync deassert): all *valid, bready, rready and rsp_* outputs are 0. cmd_ready=1. gpio_out=0. gpio_in_sync=0. Address/data outputs are 0. awprot=arprot=3'b000 always.
- FSM states: IDLE, WR (AW/W outstanding), WB (wait B), RD_A (AR outstanding), RD_D (wait R), DONE.
- IDLE: cmd_ready=1. On cmd_valid, register addr, data and strobe, then go to WR or RD_A. awvalid/wvalid or arvalid assert the next cycle.
- WR: awvalid and wvalid assert together. Each drops independently on its own ready. Go to WB once both handshakes are done; same-cycle or either order is legal.
- WB: bready=1. On bvalid, capture bresp and go to DONE.
- RD_A: arvalid until arready, then RD_D.
- RD_D: rready=1. On rvalid, capture rdata and rresp, then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. Minimum latency, zero-wait slave: accept at cycle 0, valid at cycle 1, response at cycle 2, rsp_valid at cycle 3.
- Valid signals and their payloads stay stable until handshake; they are never withdrawn except on timeout.
- Watchdog: the counter clears on command accept and counts every non-IDLE/non-DONE cycle. At TIMEOUT_CYCLES, drop all valids/readies and go to DONE with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
- Late responses arriving while IDLE are ignored.
- cmd_valid while busy is ignored (cmd_ready=0); there is no queueing.
- GPIO: gpio_out updates on the clock edge after gpio_out_we. gpio_in passes through 2 flops with 2-cycle latency.
- Reset mid-transaction aborts immediately to IDLE without rsp_valid.

Test Plan:
- Write 0x0000_00AA to addr 0x010, wstrb=4'hF, zero-wait slave -> one AW and one W handshake; awaddr=0x010, wdata=0xAA; rsp_valid 3 cycles after accept with rsp_resp=0.
- Read 0x010 from a slave returning 0xDEADBEEF after 5 wait cycles on R -> rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_timeout=0.
- Slave gives wready 4 cycles before awready -> wvalid drops first, awvalid holds; single B accepted; response OK.
- Slave never asserts arready -> after 1024 cycles arvalid drops; rsp_valid with rsp_timeout=1, rsp_resp=2'b10.
- gpio_out_we with 2'b10 -> gpio_out=2'b10 next cycle. Pulse gpio_in[0] high for 3 cycles -> gpio_in_sync[0] high 2 cycles later for 3 cycles.
- Assert aclk_reset_n low during the WB state -> bready=0 and cmd_ready=1 asynchronously; no rsp_valid; gpio_out=0.
